// File: rtl/data_memory_bank.sv
// data_memory_bank: 16-word data memory for the i281 CPU.
//   - CPU write port driven by a one-hot per-word write enable (Write_Select).
//   - Asynchronous read port (Read_Address -> Read_Data).
//   - Preload FSM (IDLE/LOAD/DONE) that streams 16 host bytes into words 0..15
//     over a valid/ready handshake.
// Optional feature macro: DATA_MEMORY_ONEHOT_CHECK_EN
//   defined     -> multi-hot CPU writes are dropped and set sticky Write_Error.
//   not defined -> every selected word is written; Write_Error tied to 0.
// Ports:
//   Clock, Reset (async, active-high)
//   Write_Select[15:0], Write_Data   : CPU write-back
//   Read_Address[3:0], Read_Data     : combinational read
//   Preload_Start/Valid/Data         : host preload request and stream
//   Preload_Ready/Busy/Done          : preload status (state decodes)
//   Write_Error                      : sticky collision flag
module data_memory_bank #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [15:0]           Write_Select,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    input  logic [3:0]            Read_Address,
    output logic [DATA_WIDTH-1:0] Read_Data,
    input  logic                  Preload_Start,
    input  logic                  Preload_Valid,
    input  logic [DATA_WIDTH-1:0] Preload_Data,
    output logic                  Preload_Ready,
    output logic                  Preload_Busy,
    output logic                  Preload_Done,
    output logic                  Write_Error
);

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  pre_we_c;
    logic [DEPTH-1:0]      cpu_we_c;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Preload FSM state and address counter
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter wraps to 0 on the final beat as the FSM exits LOAD
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pre_we_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (Preload_Start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (Preload_Valid) begin
                    pre_we_c = 1'b1;
                    cnt_d    = cnt_q + AW'(1);
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Preload_Ready = (state_q == LOAD);
    assign Preload_Busy  = (state_q == LOAD) || (state_q == DONE);
    assign Preload_Done  = (state_q == DONE);

`ifdef DATA_MEMORY_ONEHOT_CHECK_EN
    logic multi_hot_c;
    logic err_q;

    // More than one bit set iff clearing the lowest set bit leaves something
    assign multi_hot_c = |(Write_Select & (Write_Select - 16'd1));

    // CPU writes only happen in IDLE; a multi-hot select writes nothing
    always_comb begin
        cpu_we_c = '0;
        if ((state_q == IDLE) && !multi_hot_c) begin
            cpu_we_c = Write_Select;
        end
    end

    // Sticky collision flag, cleared only by reset
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            err_q <= 1'b0;
        end else if ((state_q == IDLE) && multi_hot_c) begin
            err_q <= 1'b1;
        end
    end

    assign Write_Error = err_q;
`else
    // CPU writes only happen in IDLE; every selected word is written
    always_comb begin
        cpu_we_c = '0;
        if (state_q == IDLE) begin
            cpu_we_c = Write_Select;
        end
    end

    assign Write_Error = 1'b0;
`endif

    // Storage; preload and CPU writes are exclusive by FSM state
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (pre_we_c) begin
            mem_q[cnt_q] <= Preload_Data;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cpu_we_c[i]) begin
                    mem_q[i] <= Write_Data;
                end
            end
        end
    end

    // Asynchronous read, no write-through bypass
    assign Read_Data = mem_q[Read_Address];

endmodule

// File: tb/tb_data_memory_bank.sv
// Directed testbench for data_memory_bank.
module tb_data_memory_bank;

    logic        Clock;
    logic        Reset;
    logic [15:0] Write_Select;
    logic [7:0]  Write_Data;
    logic [3:0]  Read_Address;
    logic [7:0]  Read_Data;
    logic        Preload_Start;
    logic        Preload_Valid;
    logic [7:0]  Preload_Data;
    logic        Preload_Ready;
    logic        Preload_Busy;
    logic        Preload_Done;
    logic        Write_Error;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    data_memory_bank #(.DATA_WIDTH(8)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Write_Select  (Write_Select),
        .Write_Data    (Write_Data),
        .Read_Address  (Read_Address),
        .Read_Data     (Read_Data),
        .Preload_Start (Preload_Start),
        .Preload_Valid (Preload_Valid),
        .Preload_Data  (Preload_Data),
        .Preload_Ready (Preload_Ready),
        .Preload_Busy  (Preload_Busy),
        .Preload_Done  (Preload_Done),
        .Write_Error   (Write_Error)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        step();
        for (int a = 0; a < 16; a++) begin
            Read_Address = 4'(a);
            #1;
            chk_cnt++;
            if (Read_Data !== 8'h00)
                $display("FAIL reset_word[%0d] got %h exp 00", a, Read_Data);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({Preload_Busy, Preload_Ready, Preload_Done, Write_Error} !== 4'b0000)
            $display("FAIL reset_status got busy/ready/done/err=%b exp 0000",
                     {Preload_Busy, Preload_Ready, Preload_Done, Write_Error});
        else pass_cnt++;
    endtask

    task automatic test_cpu_write();
        Write_Select = 16'h0008;
        Write_Data   = 8'h5A;
        Read_Address = 4'd3;
        #1;
        chk_cnt++;
        if (Read_Data !== 8'h00)
            $display("FAIL cpu_no_bypass got %h exp 00", Read_Data);
        else pass_cnt++;
        step();
        Write_Select = 16'h0000;
        for (int a = 0; a < 16; a++) begin
            Read_Address = 4'(a);
            #1;
            chk_cnt++;
            if (Read_Data !== ((a == 3) ? 8'h5A : 8'h00))
                $display("FAIL cpu_write_word[%0d] got %h exp %h", a, Read_Data,
                         (a == 3) ? 8'h5A : 8'h00);
            else pass_cnt++;
        end
    endtask

    task automatic test_preload();
        int done_seen = 0;
        Preload_Start = 1'b1;
        step();
        Preload_Start = 1'b0;
        chk_cnt++;
        if ({Preload_Busy, Preload_Ready, Preload_Done} !== 3'b110)
            $display("FAIL preload_enter got busy/ready/done=%b exp 110",
                     {Preload_Busy, Preload_Ready, Preload_Done});
        else pass_cnt++;
        // CPU write attempt during LOAD must be ignored
        Write_Select = 16'h0001;
        Write_Data   = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            Preload_Valid = 1'b1;
            Preload_Data  = 8'(8'h10 + i);
            // Start during LOAD is ignored
            Preload_Start = (i == 8);
            step();
            Preload_Start = 1'b0;
            if (Preload_Done === 1'b1) done_seen++;
            if (i == 4) begin
                Preload_Valid = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    step();
                    if (Preload_Done === 1'b1) done_seen++;
                    chk_cnt++;
                    if ({Preload_Busy, Preload_Ready} !== 2'b11)
                        $display("FAIL preload_stall busy/ready got %b exp 11",
                                 {Preload_Busy, Preload_Ready});
                    else pass_cnt++;
                end
            end
        end
        // One cycle after the 16th beat: DONE
        chk_cnt++;
        if ({Preload_Busy, Preload_Ready, Preload_Done} !== 3'b101)
            $display("FAIL preload_done_state got busy/ready/done=%b exp 101",
                     {Preload_Busy, Preload_Ready, Preload_Done});
        else pass_cnt++;
        Preload_Valid = 1'b0;
        step();
        Write_Select = 16'h0000;
        if (Preload_Done === 1'b1) done_seen++;
        chk_cnt++;
        if ({Preload_Busy, Preload_Ready, Preload_Done} !== 3'b000)
            $display("FAIL preload_back_idle got busy/ready/done=%b exp 000",
                     {Preload_Busy, Preload_Ready, Preload_Done});
        else pass_cnt++;
        chk_cnt++;
        if (done_seen !== 1)
            $display("FAIL preload_done_pulses got %0d exp 1", done_seen);
        else pass_cnt++;
        for (int a = 0; a < 16; a++) begin
            Read_Address = 4'(a);
            #1;
            chk_cnt++;
            if (Read_Data !== 8'(8'h10 + a))
                $display("FAIL preload_word[%0d] got %h exp %h", a, Read_Data, 8'(8'h10 + a));
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_preload();
        Preload_Start = 1'b1;
        step();
        Preload_Start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            Preload_Valid = 1'b1;
            Preload_Data  = 8'(8'hA0 + i);
            step();
        end
        Preload_Valid = 1'b0;
        Reset = 1'b1;
        #1;
        chk_cnt++;
        if ({Preload_Busy, Preload_Ready, Preload_Done} !== 3'b000)
            $display("FAIL midreset_status got busy/ready/done=%b exp 000",
                     {Preload_Busy, Preload_Ready, Preload_Done});
        else pass_cnt++;
        for (int a = 0; a < 16; a++) begin
            Read_Address = 4'(a);
            #1;
            chk_cnt++;
            if (Read_Data !== 8'h00)
                $display("FAIL midreset_word[%0d] got %h exp 00", a, Read_Data);
            else pass_cnt++;
        end
        step();
        Reset = 1'b0;
        step();
        // New preload restarts at word 0
        Preload_Start = 1'b1;
        step();
        Preload_Start = 1'b0;
        Preload_Valid = 1'b1;
        Preload_Data  = 8'hC5;
        step();
        Preload_Valid = 1'b0;
        Read_Address = 4'd0;
        #1;
        chk_cnt++;
        if (Read_Data !== 8'hC5)
            $display("FAIL restart_word0 got %h exp c5", Read_Data);
        else pass_cnt++;
        Read_Address = 4'd1;
        #1;
        chk_cnt++;
        if (Read_Data !== 8'h00)
            $display("FAIL restart_word1 got %h exp 00", Read_Data);
        else pass_cnt++;
        chk_cnt++;
        if (Preload_Busy !== 1'b1)
            $display("FAIL restart_busy got %b exp 1", Preload_Busy);
        else pass_cnt++;
        // Abandon this preload
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();
    endtask

    task automatic test_multi_hot();
        logic [7:0] exp01;
        logic       exp_err;
`ifdef DATA_MEMORY_ONEHOT_CHECK_EN
        exp01   = 8'h00;
        exp_err = 1'b1;
`else
        exp01   = 8'h77;
        exp_err = 1'b0;
`endif
        Write_Select = 16'h0003;
        Write_Data   = 8'h77;
        step();
        Write_Select = 16'h0000;
        for (int a = 0; a < 3; a++) begin
            Read_Address = 4'(a);
            #1;
            chk_cnt++;
            if (Read_Data !== ((a < 2) ? exp01 : 8'h00))
                $display("FAIL multihot_word[%0d] got %h exp %h", a, Read_Data,
                         (a < 2) ? exp01 : 8'h00);
            else pass_cnt++;
        end
        chk_cnt++;
        if (Write_Error !== exp_err)
            $display("FAIL multihot_err got %b exp %b", Write_Error, exp_err);
        else pass_cnt++;
        // Later single-hot write still works; error flag remains
        Write_Select = 16'h0004;
        Write_Data   = 8'h33;
        step();
        Write_Select = 16'h0000;
        step();
        Read_Address = 4'd2;
        #1;
        chk_cnt++;
        if (Read_Data !== 8'h33)
            $display("FAIL onehot_after_word2 got %h exp 33", Read_Data);
        else pass_cnt++;
        chk_cnt++;
        if (Write_Error !== exp_err)
            $display("FAIL err_sticky got %b exp %b", Write_Error, exp_err);
        else pass_cnt++;
    endtask

    initial begin
        Reset         = 1'b1;
        Write_Select  = 16'h0000;
        Write_Data    = 8'h00;
        Read_Address  = 4'd0;
        Preload_Start = 1'b0;
        Preload_Valid = 1'b0;
        Preload_Data  = 8'h00;
        test_reset();
        test_cpu_write();
        test_preload();
        test_reset_mid_preload();
        test_multi_hot();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/data_memory_bank.md
# data_memory_bank

Sixteen-entry data memory for the i281 CPU, sitting directly downstream of the 4-to-16 write-enable decoder: it consumes the decoder's one-hot 16-bit output as per-word write enables and stores the CPU write-back byte in the selected word. It also exposes an asynchronous read port to the datapath. A preload state machine lets the visualizer host stream 16 initial bytes into memory over a valid/ready handshake before the program runs.

## Interface

- DATA_WIDTH, 8, width of each memory word and of all data ports.

- Clock  input  1  rising-edge system clock.
- Reset  input  1  asynchronous, active-high; clears memory and FSM.
- Write_Select  input  16  one-hot per-word write enable from the 4-to-16 decoder; all-zero means no write.
- Write_Data  input  DATA_WIDTH  CPU write-back byte.
- Read_Address  input  4  word index for the read port.
- Read_Data  output  DATA_WIDTH  contents of the word at Read_Address.
- Preload_Start  input  1  single-cycle request to begin a preload.
- Preload_Valid  input  1  host presents Preload_Data.
- Preload_Data  input  DATA_WIDTH  preload byte.
- Preload_Ready  output  1  block accepts a byte this cycle.
- Preload_Busy  output  1  high while FSM is in LOAD or DONE.
- Preload_Done  output  1  one-cycle pulse after the 16th byte is written.
- Write_Error  output  1  sticky collision flag (see Configuration).

## Operation

- Storage: 16 words x DATA_WIDTH; all words reset to 0.
- Read: combinational, Read_Data = mem[Read_Address]; a write lands at the clock edge and is visible from the following cycle (no write-through bypass).
- CPU write: in IDLE, at each rising edge every word i with Write_Select[i]=1 takes Write_Data.
- FSM states: IDLE, LOAD, DONE; reset state IDLE.
  - IDLE: Preload_Start=1 -> LOAD, address counter <= 0.
  - LOAD: Preload_Ready=1; on Preload_Valid & Preload_Ready, mem[counter] <= Preload_Data, counter <= counter+1; the beat that writes word 15 -> DONE. Valid low stalls with no state change.
  - DONE: Preload_Done=1 for exactly one cycle, then -> IDLE.
- Priority: in LOAD and DONE, Write_Select is ignored (no CPU writes). Preload_Start in LOAD or DONE is ignored.
- Counter is 4 bits; it wraps to 0 on the final beat, which is harmless because the FSM leaves LOAD.
- Reset mid-preload: FSM -> IDLE, counter -> 0, all words -> 0, partial preload discarded.

## Timing

- Reset values: Read_Data = 0 for any address, Preload_Ready=0, Preload_Busy=0, Preload_Done=0, Write_Error=0.
- Preload_Ready and Preload_Busy are registered-state decodes: both rise the cycle after Preload_Start is sampled.
- Minimum preload: 1 start cycle + 16 beat cycles + 1 DONE cycle; Busy covers the beat and DONE cycles.
- CPU write latency: 1 clock (write at edge, read-visible next cycle).

## Configuration

- DATA_MEMORY_ONEHOT_CHECK_EN defined: a CPU write with more than one Write_Select bit set writes nothing and sets Write_Error (sticky until Reset). Preload writes are never checked.
- Not defined: every selected word is written; Write_Error is tied to 0.

## Test plan

- Reset, then read all 16 addresses -> Read_Data = 0x00 each; Busy/Ready/Done = 0.
- Write_Select=16'h0008, Write_Data=0x5A -> next cycle Read_Address=3 gives 0x5A; all other words remain 0.
- Preload_Start, then 16 beats of 0x10..0x1F with Valid deasserted for 2 cycles after the 5th beat -> words 0..15 = 0x10..0x1F, Done pulses exactly once, one cycle after the 16th beat.
- During LOAD, drive Write_Select=16'h0001, Write_Data=0xFF -> word 0 holds the preload value, not 0xFF.
- Assert Reset after 7 preload beats -> all words 0, FSM IDLE; a new preload then starts writing at word 0.
- Write_Select=16'h0003, Write_Data=0x77: with the macro -> words 0 and 1 unchanged, Write_Error=1 and stays 1; without the macro -> words 0 and 1 = 0x77, Write_Error=0.
